// File: rtl/dram_cmd_scheduler_if.sv
//------------------------------------------------------------------------------
// dram_cmd_scheduler_if : request, refresh and DRAM command bundle
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dram_cmd_scheduler_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);
  localparam int CW = $clog2(NUM_OF_COLS);

  logic                    req_val;
  logic                    req_ready;
  logic                    req_rw;
  logic [BW-1:0]           req_bank;
  logic [RW-1:0]           req_row;
  logic [CW-1:0]           req_col;
  logic                    refresh_flag;
  logic                    refresh_ack;
  logic                    cmd_req;
  logic                    cmd_ack;
  logic [2:0]              cmd;
  logic [BW-1:0]           cmd_bank;
  logic [RW-1:0]           cmd_row;
  logic [CW-1:0]           cmd_col;
  logic                    done;
  logic [NUM_OF_BANKS-1:0] open_bank_mask;

  modport master (
    output req_val, req_rw, req_bank, req_row, req_col, refresh_flag, cmd_ack,
    input  req_ready, refresh_ack, cmd_req, cmd, cmd_bank, cmd_row, cmd_col,
           done, open_bank_mask
  );

  modport slave (
    input  req_val, req_rw, req_bank, req_row, req_col, refresh_flag, cmd_ack,
    output req_ready, refresh_ack, cmd_req, cmd, cmd_bank, cmd_row, cmd_col,
           done, open_bank_mask
  );
endinterface

`default_nettype wire

// File: rtl/dram_cmd_scheduler.sv
//------------------------------------------------------------------------------
// dram_cmd_scheduler : open-page DRAM command sequencer with refresh handling
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dram_cmd_scheduler #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  dram_cmd_scheduler_if.slave bus
);
  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);
  localparam int CW = $clog2(NUM_OF_COLS);

  localparam logic [2:0] C_CMD_NOP = 3'b000;
  localparam logic [2:0] C_CMD_ACT = 3'b001;
  localparam logic [2:0] C_CMD_RD  = 3'b010;
  localparam logic [2:0] C_CMD_WR  = 3'b011;
  localparam logic [2:0] C_CMD_PRE = 3'b100;
  localparam logic [2:0] C_CMD_REF = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_PRE, S_ACT, S_ACCESS, S_DONE, S_REF_PRE, S_REF
  } state_t;

  state_t                  state_q, state_d;
  logic                    rw_q, rw_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [NUM_OF_BANKS-1:0] mask_q, mask_d;
  logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
  logic [RW-1:0]           open_row_d [NUM_OF_BANKS];
  logic                    pending_q, pending_d;
  logic                    refresh_ack_q, refresh_ack_d;
  logic                    done_q, done_d;
  logic                    cmd_req_q, cmd_req_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [BW-1:0]           cmd_bank_q, cmd_bank_d;
  logic [RW-1:0]           cmd_row_q, cmd_row_d;
  logic [CW-1:0]           cmd_col_q, cmd_col_d;
  logic [BW-1:0]           w_low_bank;
  logic                    w_fire;
  logic                    w_ref_due;

  assign w_fire    = cmd_req_q & bus.cmd_ack;
  // A refresh pulse arriving this cycle already blocks acceptance.
  assign w_ref_due = pending_q | bus.refresh_flag;

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    bank_d        = bank_q;
    row_d         = row_q;
    col_d         = col_q;
    mask_d        = mask_q;
    open_row_d    = open_row_q;
    pending_d     = w_ref_due;
    refresh_ack_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_ref_due) begin
          state_d = (mask_q == '0) ? S_REF : S_REF_PRE;
        end else if (bus.req_val) begin
          rw_d    = bus.req_rw;
          bank_d  = bus.req_bank;
          row_d   = bus.req_row;
          col_d   = bus.req_col;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!mask_q[bank_q])                 state_d = S_ACT;
        else if (open_row_q[bank_q] == row_q) state_d = S_ACCESS;
        else                                  state_d = S_PRE;
      end
      S_PRE: begin
        if (w_fire) begin
          mask_d[bank_q] = 1'b0;
          state_d        = S_ACT;
        end
      end
      S_ACT: begin
        if (w_fire) begin
          mask_d[bank_q]     = 1'b1;
          open_row_d[bank_q] = row_q;
          state_d            = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_fire) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_REF_PRE: begin
        if (w_fire) begin
          mask_d[cmd_bank_q] = 1'b0;
          if (mask_d == '0) state_d = S_REF;
        end
      end
      S_REF: begin
        if (w_fire) begin
          mask_d        = '0;
          refresh_ack_d = 1'b1;
          pending_d     = bus.refresh_flag;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    w_low_bank = '0;
    for (int i = NUM_OF_BANKS - 1; i >= 0; i--) begin
      if (mask_d[i]) w_low_bank = BW'(i);
    end

    // Command outputs are a registered image of the state being entered.
    done_d     = (state_d == S_DONE);
    cmd_req_d  = 1'b0;
    cmd_d      = C_CMD_NOP;
    cmd_bank_d = '0;
    cmd_row_d  = '0;
    cmd_col_d  = '0;
    case (state_d)
      S_PRE: begin
        cmd_req_d  = 1'b1;
        cmd_d      = C_CMD_PRE;
        cmd_bank_d = bank_d;
      end
      S_ACT: begin
        cmd_req_d  = 1'b1;
        cmd_d      = C_CMD_ACT;
        cmd_bank_d = bank_d;
        cmd_row_d  = row_d;
      end
      S_ACCESS: begin
        cmd_req_d  = 1'b1;
        cmd_d      = rw_d ? C_CMD_WR : C_CMD_RD;
        cmd_bank_d = bank_d;
        cmd_row_d  = row_d;
        cmd_col_d  = col_d;
      end
      S_REF_PRE: begin
        cmd_req_d  = 1'b1;
        cmd_d      = C_CMD_PRE;
        cmd_bank_d = w_low_bank;
      end
      S_REF: begin
        cmd_req_d  = 1'b1;
        cmd_d      = C_CMD_REF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q       <= S_IDLE;
      rw_q          <= 1'b0;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      mask_q        <= '0;
      open_row_q    <= '{default: '0};
      pending_q     <= 1'b0;
      refresh_ack_q <= 1'b0;
      done_q        <= 1'b0;
      cmd_req_q     <= 1'b0;
      cmd_q         <= C_CMD_NOP;
      cmd_bank_q    <= '0;
      cmd_row_q     <= '0;
      cmd_col_q     <= '0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      mask_q        <= mask_d;
      open_row_q    <= open_row_d;
      pending_q     <= pending_d;
      refresh_ack_q <= refresh_ack_d;
      done_q        <= done_d;
      cmd_req_q     <= cmd_req_d;
      cmd_q         <= cmd_d;
      cmd_bank_q    <= cmd_bank_d;
      cmd_row_q     <= cmd_row_d;
      cmd_col_q     <= cmd_col_d;
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE) && !w_ref_due;
  assign bus.refresh_ack    = refresh_ack_q;
  assign bus.cmd_req        = cmd_req_q;
  assign bus.cmd            = cmd_q;
  assign bus.cmd_bank       = cmd_bank_q;
  assign bus.cmd_row        = cmd_row_q;
  assign bus.cmd_col        = cmd_col_q;
  assign bus.done           = done_q;
  assign bus.open_bank_mask = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_cmd_scheduler.sv
//------------------------------------------------------------------------------
// tb_dram_cmd_scheduler : vector table plus command scoreboard for the scheduler
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dram_cmd_scheduler;
  localparam int NB = 8;
  localparam int NR = 128;
  localparam int NC = 8;
  localparam int BW = 3;
  localparam int RW = 7;
  localparam int CW = 3;

  localparam logic [2:0] C_NOP = 3'b000;
  localparam logic [2:0] C_ACT = 3'b001;
  localparam logic [2:0] C_RD  = 3'b010;
  localparam logic [2:0] C_WR  = 3'b011;
  localparam logic [2:0] C_PRE = 3'b100;
  localparam logic [2:0] C_REF = 3'b101;

  typedef struct packed {
    logic [2:0]    cmd;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } cmd_t;

  typedef struct {
    logic          rw;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    int            lat;
    logic [NB-1:0] mask;
  } vec_t;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  dram_cmd_scheduler_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus ();

  dram_cmd_scheduler #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  cmd_t          exp_q[$];
  cmd_t          mon_a, mon_e;
  vec_t          vecs[8];
  logic          m_open[NB];
  logic [RW-1:0] m_row[NB];
  int n_vec = 0, n_bad = 0, n_refack = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  function automatic cmd_t relevant(input cmd_t x);
    cmd_t y = x;
    if (y.cmd == C_PRE) begin
      y.row = '0;
      y.col = '0;
    end else if (y.cmd == C_ACT) begin
      y.col = '0;
    end
    return y;
  endfunction

  function automatic cmd_t mk(input logic [2:0] c, input int b, input int r, input int col);
    cmd_t x;
    x.cmd  = c;
    x.bank = BW'(b);
    x.row  = RW'(r);
    x.col  = CW'(col);
    return x;
  endfunction

  // Reference model: open-page policy expressed as the expected command stream.
  task automatic push_req(input logic rw, input int b, input int r, input int c);
    if (!(m_open[b] && m_row[b] == RW'(r))) begin
      if (m_open[b]) exp_q.push_back(mk(C_PRE, b, 0, 0));
      exp_q.push_back(mk(C_ACT, b, r, 0));
      m_open[b] = 1'b1;
      m_row[b]  = RW'(r);
    end
    exp_q.push_back(mk(rw ? C_WR : C_RD, b, r, c));
  endtask

  task automatic push_refresh();
    for (int i = 0; i < NB; i++) begin
      if (m_open[i]) exp_q.push_back(mk(C_PRE, i, 0, 0));
      m_open[i] = 1'b0;
    end
    exp_q.push_back(mk(C_REF, 0, 0, 0));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input logic rw, input int b, input int r, input int c, output int lat);
    int t = 0;
    bus.req_val  = 1'b1;
    bus.req_rw   = rw;
    bus.req_bank = BW'(b);
    bus.req_row  = RW'(r);
    bus.req_col  = CW'(c);
    #1;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!bus.req_ready) begin
      fail_now("accept_timeout");
      bus.req_val = 1'b0;
      lat = -1;
      return;
    end
    @(negedge clk);
    #1;
    bus.req_val  = 1'b0;
    bus.req_rw   = 1'($urandom);
    bus.req_bank = BW'($urandom);
    bus.req_row  = RW'($urandom);
    bus.req_col  = CW'($urandom);
    lat = 1;
    #1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      #2;
      lat++;
    end
    if (!bus.done) fail_now("done_timeout");
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst_b) begin
      if (bus.cmd_req && bus.cmd_ack) begin
        mon_a = '{cmd: bus.cmd, bank: bus.cmd_bank, row: bus.cmd_row, col: bus.cmd_col};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_cmd: got 0x%0h, expected no command", mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd", {16'h0, relevant(mon_a)}, {16'h0, relevant(mon_e)});
        end
      end
      if (!bus.cmd_req) chk("nop_when_idle", {29'h0, bus.cmd}, {29'h0, C_NOP});
      if (bus.refresh_ack) begin
        n_refack++;
        chk("mask_after_ref", {24'h0, bus.open_bank_mask}, 32'h0);
      end
      if (bus.done) n_done++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int lat, base;
    logic [2:0]    hold_cmd;
    logic [RW-1:0] hold_row;
    logic          found;

    vecs[0] = '{1'b0, 3'd2, 7'd5,   3'd3, 4, 8'h04};
    vecs[1] = '{1'b1, 3'd2, 7'd5,   3'd7, 3, 8'h04};
    vecs[2] = '{1'b0, 3'd2, 7'd9,   3'd0, 5, 8'h04};
    vecs[3] = '{1'b1, 3'd1, 7'd3,   3'd1, 4, 8'h06};
    vecs[4] = '{1'b0, 3'd6, 7'd127, 3'd7, 4, 8'h46};
    vecs[5] = '{1'b0, 3'd6, 7'd127, 3'd0, 3, 8'h46};
    vecs[6] = '{1'b1, 3'd7, 7'd0,   3'd0, 4, 8'hC6};
    vecs[7] = '{1'b1, 3'd1, 7'd4,   3'd2, 5, 8'hC6};

    model_clear();
    rst_b            = 1'b1;
    bus.req_val      = 1'b0;
    bus.req_rw       = 1'b0;
    bus.req_bank     = '0;
    bus.req_row      = '0;
    bus.req_col      = '0;
    bus.refresh_flag = 1'b0;
    bus.cmd_ack      = 1'b1;

    repeat (3) tick();
    chk("reset_outputs",
        {5'h0, bus.cmd_req, bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col,
         bus.done, bus.refresh_ack, bus.open_bank_mask}, 32'h0);
    tick();
    rst_b = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // Vector table: latency, readiness and bank mask after each access.
    for (int i = 0; i < 8; i++) begin
      tick();
      push_req(vecs[i].rw, vecs[i].bank, vecs[i].row, vecs[i].col);
      send_req(vecs[i].rw, vecs[i].bank, vecs[i].row, vecs[i].col, lat);
      chk($sformatf("latency_v%0d", i), lat, vecs[i].lat);
      @(negedge clk);
      #2;
      chk($sformatf("ready_v%0d", i), {31'h0, bus.req_ready}, 32'h1);
      chk($sformatf("mask_v%0d", i), {24'h0, bus.open_bank_mask}, {24'h0, vecs[i].mask});
      chk($sformatf("queue_v%0d", i), exp_q.size(), 0);
    end

    // ACT held without acknowledge for five cycles.
    tick();
    push_req(1'b0, 5, 10, 1);
    bus.cmd_ack = 1'b0;
    fork
      send_req(1'b0, 5, 10, 1, lat);
      begin
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
          tick();
          found = bus.cmd_req;
        end
        if (!found) fail_now("stall_act_timeout");
        hold_cmd = bus.cmd;
        hold_row = bus.cmd_row;
        chk("stall_is_act", {29'h0, hold_cmd}, {29'h0, C_ACT});
        for (int k = 0; k < 5; k++) begin
          chk("stall_stable", {21'h0, bus.cmd_req, bus.cmd, bus.cmd_row},
              {21'h0, 1'b1, C_ACT, 7'd10});
          tick();
        end
        bus.cmd_ack = 1'b1;
      end
    join
    chk("stall_latency", lat, 9);
    tick();
    chk("stall_mask", {24'h0, bus.open_bank_mask}, 32'h0000_00E6);

    // Reset asserted while a row-hit read waits in ACCESS.
    tick();
    bus.cmd_ack  = 1'b0;
    bus.req_val  = 1'b1;
    bus.req_rw   = 1'b0;
    bus.req_bank = 3'd2;
    bus.req_row  = 7'd9;
    bus.req_col  = 3'd4;
    #1;
    chk("ready_before_abort", {31'h0, bus.req_ready}, 32'h1);
    tick();
    bus.req_val = 1'b0;
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      tick();
      found = bus.cmd_req;
    end
    if (!found) fail_now("access_timeout");
    chk("access_cmd", {29'h0, bus.cmd}, {29'h0, C_RD});
    rst_b = 1'b1;
    #1;
    chk("async_drop", {31'h0, bus.cmd_req}, 32'h0);
    chk("abort_mask", {24'h0, bus.open_bank_mask}, 32'h0);
    exp_q.delete();
    model_clear();
    repeat (2) begin
      tick();
      chk("no_done_in_reset", {31'h0, bus.done}, 32'h0);
    end
    bus.cmd_ack = 1'b1;
    rst_b = 1'b0;
    #1;
    chk("ready_after_abort", {31'h0, bus.req_ready}, 32'h1);
    repeat (3) begin
      tick();
      chk("no_done_after_abort", {31'h0, bus.done}, 32'h0);
    end

    // Banks 1 and 6 open, then refresh and a request on the same cycle.
    push_req(1'b1, 1, 3, 0);
    send_req(1'b1, 1, 3, 0, lat);
    chk("open_b1_latency", lat, 4);
    tick();
    push_req(1'b0, 6, 2, 1);
    send_req(1'b0, 6, 2, 1, lat);
    tick();
    chk("mask_b1_b6", {24'h0, bus.open_bank_mask}, 32'h0000_0042);
    base = n_refack;
    push_refresh();
    push_req(1'b0, 1, 3, 5);
    bus.refresh_flag = 1'b1;
    bus.req_val      = 1'b1;
    bus.req_rw       = 1'b0;
    bus.req_bank     = 3'd1;
    bus.req_row      = 7'd3;
    bus.req_col      = 3'd5;
    #1;
    chk("ready_blocked_by_refresh", {31'h0, bus.req_ready}, 32'h0);
    tick();
    bus.refresh_flag = 1'b0;
    send_req(1'b0, 1, 3, 5, lat);
    chk("refresh_ack_count", n_refack - base, 1);
    tick();
    chk("mask_after_req", {24'h0, bus.open_bank_mask}, 32'h0000_0002);
    chk("queue_after_ref", exp_q.size(), 0);

    // Second refresh pulse while one is already pending is absorbed.
    base = n_refack;
    push_refresh();
    bus.refresh_flag = 1'b1;
    tick();
    tick();
    bus.refresh_flag = 1'b0;
    for (int w = 0; w < 30 && n_refack == base; w++) tick();
    if (n_refack == base) fail_now("refresh_timeout");
    repeat (6) tick();
    chk("single_refresh", n_refack - base, 1);
    chk("mask_idle_after_ref", {24'h0, bus.open_bank_mask}, 32'h0);
    chk("ready_after_ref", {31'h0, bus.req_ready}, 32'h1);
    chk("queue_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_cmd_scheduler.md
DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_OF_BANKS, default 8, bank count; NUM_OF_ROWS, default 128, rows per bank; NUM_OF_COLS, default 8, columns per row.
REQ-002 Derived widths SHALL be: BW=$clog2(NUM_OF_BANKS); RW=$clog2(NUM_OF_ROWS); CW=$clog2(NUM_OF_COLS).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-high; asserted when 1.
REQ-005 req_val  input  1  translated request valid.
REQ-006 req_ready  output  1  scheduler can accept a request.
REQ-007 req_rw  input  1  1 = write, 0 = read.
REQ-008 req_bank / req_row / req_col  input  BW / RW / CW  target address.
REQ-009 refresh_flag  input  1  single-cycle refresh-due pulse from the refresh counter.
REQ-010 refresh_ack  output  1  one-cycle pulse when the refresh sequence completes.
REQ-011 cmd_req  output  1  command valid toward the DRAM.
REQ-012 cmd_ack  input  1  DRAM accepts the presented command.
REQ-013 cmd  output  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF.
REQ-014 cmd_bank / cmd_row / cmd_col  output  BW / RW / CW  command address.
REQ-015 done  output  1  one-cycle pulse when a read/write access completes.
REQ-016 open_bank_mask  output  NUM_OF_BANKS  bit i = 1 while bank i has an open row.

Function
REQ-017 The state machine SHALL have states IDLE, DECODE, PRE, ACT, ACCESS, DONE, REF_PRE and REF.
REQ-018 req_ready SHALL be 1 only in IDLE with no refresh pending; a request is accepted on a cycle with req_val=1 and req_ready=1, and its fields are latched.
REQ-019 A command SHALL complete on any cycle with cmd_req=1 and cmd_ack=1.
REQ-020 cmd and cmd_* fields SHALL stay stable while cmd_req=1 until acknowledged.
REQ-021 cmd_req MAY stay high across consecutive commands.
REQ-022 cmd SHALL be NOP whenever cmd_req=0.
REQ-023 A per-bank open flag and open-row register SHALL be kept: ACT sets the flag and row, PRE clears the flag, REF leaves all banks closed.
REQ-024 DECODE SHALL take one cycle and select the next state:
- row hit (bank open, same row) -> ACCESS;
- bank closed -> ACT;
- row conflict -> PRE.
REQ-025 PRE SHALL go to ACT on ack, ACT to ACCESS on ack, and ACCESS to DONE on ack.
REQ-026 ACCESS SHALL issue RD when req_rw=0 and WR when req_rw=1, at the latched bank, row and column.
REQ-027 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-028 Row-hit latency with cmd_ack tied 1:
- accept at cycle 0;
- cmd_req=1 with RD/WR at cycle 2;
- done=1 at cycle 3;
- req_ready=1 at cycle 4.
REQ-029 Each of ACT and PRE SHALL add one cycle when cmd_ack is tied 1; each cycle cmd_ack=0 adds one cycle.
REQ-030 refresh_flag SHALL set a sticky refresh_pending bit in any state; a second pulse while already pending SHALL be absorbed.
REQ-031 In IDLE, refresh_pending SHALL take priority over req_val when both are present on the same cycle.
REQ-032 A refresh arriving mid-transaction SHALL NOT abort it; it is serviced on the next IDLE.
REQ-033 REF_PRE SHALL issue PRE to each open bank, lowest index first, one ack each; with no banks open it SHALL go straight to REF.
REQ-034 REF SHALL issue REF with cmd_bank/row/col = 0. On ack: refresh_ack pulses for one cycle, refresh_pending clears, and the state returns to IDLE.
REQ-035 A refresh_flag on the same cycle as the REF ack SHALL re-set refresh_pending.
REQ-036 req_* inputs SHALL be ignored outside an accept cycle.

Reset
REQ-037 While rst_b=1, state SHALL be IDLE and the following SHALL be 0: cmd_req, cmd (NOP), cmd_bank, cmd_row, cmd_col, done, refresh_ack, open_bank_mask, refresh_pending and all open-row registers.
REQ-038 Assertion of rst_b mid-sequence SHALL drop cmd_req immediately (asynchronously) and discard the in-flight request.
REQ-039 req_ready SHALL be 1 on the first cycle after rst_b deasserts.

Verification
REQ-040 Reset, then RD bank 2 row 5 col 3 with ack=1 -> ACT(2,5), RD(2,5,3), done; open_bank_mask=8'h04.
REQ-041 Then WR bank 2 row 5 col 7 -> single WR(2,5,7) (row hit); done=1 at cycle 3 after accept.
REQ-042 Then RD bank 2 row 9 col 0 -> PRE(2), ACT(2,9), RD(2,9,0); mask stays 8'h04.
REQ-043 Banks 1 and 6 open, refresh_flag and req_val on the same IDLE cycle -> PRE(1), PRE(6), REF, refresh_ack, then request serviced via ACT; mask 0 after REF.
REQ-044 Hold cmd_ack=0 for 5 cycles during ACT -> cmd/cmd_row stable throughout, sequence resumes on ack.
REQ-045 rst_b=1 during ACCESS -> cmd_req=0 without waiting for a clock edge; mask=0; no done pulse.
